// File: rtl/ama_riscv_mem_rsp_if.sv
// Valid/ready channel carrying a W-bit payload.
// TX drives valid/data, RX drives ready.
interface rv_if #(
  parameter int W = 32
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport TX (output valid, output data, input ready);
  modport RX (input valid, input data, output ready);
endinterface

// File: rtl/ama_riscv_mem_rsp.sv
// Block memory responder: in-order, fixed-latency reads, byte-masked writes.
// Optional flush port under AMA_RISCV_MEM_RSP_FLUSH_EN.
module ama_riscv_mem_rsp #(
  parameter int AW      = 8,
  parameter int DW      = 128,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  rv_if.RX                req,
  rv_if.TX                rsp,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic [DW/8-1:0] wr_be
`ifdef AMA_RISCV_MEM_RSP_FLUSH_EN
  ,
  input  logic            flush
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DW-1:0] mem [2**AW];

  logic [AW-1:0]    q_addr [DEPTH];
  logic [3:0]       q_tmr  [DEPTH];
  logic [DEPTH-1:0] q_vld;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    cnt;

  logic push;
  logic pop;
  logic fl;

`ifdef AMA_RISCV_MEM_RSP_FLUSH_EN
  assign fl = flush;
`else
  assign fl = 1'b0;
`endif

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ready uses registered count only: no same-cycle pop bypass
  assign req.ready = rst && (cnt < CW'(DEPTH));
  assign rsp.valid = rst && (cnt != '0) && (q_tmr[head] == 4'd0);
  assign rsp.data  = rsp.valid ? mem[q_addr[head]] : '0;

  assign push = req.valid && req.ready;
  assign pop  = rsp.valid && rsp.ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      q_vld <= '0;
    end else if (fl) begin
      head  <= tail;
      cnt   <= '0;
      q_vld <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q_vld[i] && (q_tmr[i] != 4'd0))
          q_tmr[i] <= q_tmr[i] - 4'd1;
      end
      if (pop) begin
        q_vld[head] <= 1'b0;
        head        <= nxt(head);
      end
      if (push) begin
        q_vld[tail]  <= 1'b1;
        q_addr[tail] <= req.data;
        q_tmr[tail]  <= 4'(LATENCY - 1);
        tail         <= nxt(tail);
      end
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // array is never reset; writes land regardless of queue state
  always_ff @(posedge clk) begin
    for (int b = 0; b < DW/8; b++) begin
      if (wr_en && wr_be[b])
        mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

endmodule
